// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory load/store path.
//   - DMop[1:0] size encodings, shared with the load extender.
//   - State encoding of the store controller.
//   - Helpers: byte-lane mask, store legality check, store-value replication.
package dm_pkg;

  localparam logic [1:0] DM_BYTE = 2'b00;
  localparam logic [1:0] DM_HALF = 2'b01;
  localparam logic [1:0] DM_WORD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_MERGE,
    ST_WRITE,
    ST_DONE
  } dm_state_e;

  // Byte lanes touched by a store of size op at byte offset lane.
  function automatic logic [3:0] lane_mask(input logic [1:0] op, input logic [1:0] lane);
    case (op)
      DM_BYTE: lane_mask = 4'b0001 << lane;
      DM_HALF: lane_mask = lane[1] ? 4'b1100 : 4'b0011;
      DM_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  // Illegal size code, or an access not aligned to its own size.
  function automatic logic store_illegal(input logic [1:0] op, input logic [1:0] lane);
    store_illegal = (op == 2'b10)
                  || ((op == DM_HALF) && lane[0])
                  || ((op == DM_WORD) && (lane != 2'b00));
  endfunction

  // Store value copied into every lane it could land in.
  function automatic logic [31:0] repl_word(input logic [1:0] op, input logic [31:0] data);
    case (op)
      DM_BYTE: repl_word = {4{data[7:0]}};
      DM_HALF: repl_word = {2{data[15:0]}};
      default: repl_word = data;
    endcase
  endfunction

endpackage

// File: rtl/dm_store_merge.sv
// Combinational lane merge for sub-word stores.
//   old_word  : word currently in memory
//   data      : store data, byte/half in the LSBs
//   op, lane  : store size and byte offset
//   new_word  : old_word with the addressed lanes replaced by the store value
//   rep_word  : store value replicated into all lanes
//   be        : byte-lane mask of the store
import dm_pkg::*;

module dm_store_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] data,
  input  logic [1:0]  op,
  input  logic [1:0]  lane,
  output logic [31:0] new_word,
  output logic [31:0] rep_word,
  output logic [3:0]  be
);

  logic [31:0] bit_mask;

  assign be       = lane_mask(op, lane);
  assign rep_word = repl_word(op, data);
  assign bit_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  // Replication puts the store value in every lane, so masking selects it.
  assign new_word = (old_word & ~bit_mask) | (rep_word & bit_mask);

endmodule

// File: rtl/dm_store_ctrl.sv
// Store controller for sb/sh/sw into a word-wide data memory.
// Without byte enables, sub-word stores run read -> merge -> write.
// Build option: define DM_STORE_BYTE_ENABLE_EN when the memory honours
// mem_be; sub-word stores then go straight to WRITE with a lane mask.
//   clk, rst      : clock, synchronous active-high reset
//   req           : start a store (accepted only in IDLE)
//   addr, wdata   : byte address and store data
//   DMop          : [1:0] size (00 byte, 01 half, 11 word), [2] unused
//   busy/done/err : status; err qualifies the done pulse
//   mem_*         : data-memory port (aligned address, strobes, data, lanes)
import dm_pkg::*;

module dm_store_ctrl #(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [2:0]        DMop,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be
);

  localparam int CNT_W = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT);

  dm_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        op_q, op_d;
  logic              err_q, err_d;
  logic [31:0]       wbuf_q, wbuf_d;
  logic [3:0]        be_q, be_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_o_q, err_o_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;

  logic        in_idle;
  logic [31:0] m_data;
  logic [1:0]  m_op, m_lane;
  logic [31:0] mrg_new, mrg_rep;
  logic [3:0]  mrg_be;
  logic        unused_op_hi;

  assign unused_op_hi = DMop[2];

  // In IDLE the merge sees the incoming request (byte-enable path writes on
  // the next cycle); afterwards it sees the latched request.
  assign in_idle = (state_q == ST_IDLE);
  assign m_data  = in_idle ? wdata     : wdata_q;
  assign m_op    = in_idle ? DMop[1:0] : op_q;
  assign m_lane  = in_idle ? addr[1:0] : addr_q[1:0];

  dm_store_merge u_merge (
    .old_word (mem_rdata),
    .data     (m_data),
    .op       (m_op),
    .lane     (m_lane),
    .new_word (mrg_new),
    .rep_word (mrg_rep),
    .be       (mrg_be)
  );

`ifndef DM_STORE_BYTE_ENABLE_EN
  logic [35:0] unused_mrg;
  assign unused_mrg = {mrg_rep, mrg_be};
`endif

  // NOTE: every signal gets a default at the top so no path leaves one
  // unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    err_d   = err_q;
    wbuf_d  = wbuf_q;
    be_d    = be_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = addr;
          wdata_d = wdata;
          op_d    = DMop[1:0];
          if (store_illegal(DMop[1:0], addr[1:0])) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (DMop[1:0] == DM_WORD) begin
            wbuf_d  = wdata;
            be_d    = 4'b1111;
            state_d = ST_WRITE;
          end else begin
`ifdef DM_STORE_BYTE_ENABLE_EN
            wbuf_d  = mrg_rep;
            be_d    = mrg_be;
            state_d = ST_WRITE;
`else
            state_d = ST_READ;
`endif
          end
        end
      end
      ST_READ: begin
        cnt_d   = CNT_W'(1);
        state_d = ST_MERGE;
      end
      ST_MERGE: begin
        // Read data is valid in the RD_LAT-th cycle after the read strobe.
        if (cnt_q == CNT_LAST) begin
          wbuf_d  = mrg_new;
          state_d = ST_WRITE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state, so they line up with it.
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    err_o_d     = (state_d == ST_DONE) && err_d;
    mem_rd_d    = (state_d == ST_READ);
    mem_wr_d    = (state_d == ST_WRITE);
    mem_addr_d  = '0;
    if ((state_d == ST_READ) || (state_d == ST_MERGE) || (state_d == ST_WRITE))
      mem_addr_d = {addr_d[ADDR_W-1:2], 2'b00};
    mem_wdata_d = (state_d == ST_WRITE) ? wbuf_d : 32'h0;
    mem_be_d    = (state_d == ST_WRITE) ? be_d : 4'b1111;
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      op_q        <= '0;
      err_q       <= 1'b0;
      wbuf_q      <= '0;
      be_q        <= 4'b1111;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_o_q     <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= 4'b1111;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      op_q        <= op_d;
      err_q       <= err_d;
      wbuf_q      <= wbuf_d;
      be_q        <= be_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_o_q     <= err_o_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_o_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_dm_store_ctrl.sv
// Directed bench for dm_store_ctrl: one instance with RD_LAT=1 and one with
// RD_LAT=3, each with a memory model that returns read data only in the
// cycle RD_LAT after its read strobe. Expectations follow the build option.
module tb_dm_store_ctrl;

`ifdef DM_STORE_BYTE_ENABLE_EN
  localparam bit BE = 1'b1;
`else
  localparam bit BE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, sel;
  logic [31:0] addr, wdata, rd_word;
  logic [2:0]  dmop;

  logic        req1, busy1, done1, err1, rd1, wr1;
  logic [31:0] maddr1, mwdata1, rdata1;
  logic [3:0]  be1;
  logic        req3, busy3, done3, err3, rd3, wr3;
  logic [31:0] maddr3, mwdata3, rdata3;
  logic [3:0]  be3;

  assign req1 = req & ~sel;
  assign req3 = req & sel;

  dm_store_ctrl #(.ADDR_W(32), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .req(req1), .addr(addr), .wdata(wdata), .DMop(dmop),
    .busy(busy1), .done(done1), .err(err1), .mem_addr(maddr1), .mem_rd(rd1),
    .mem_rdata(rdata1), .mem_wr(wr1), .mem_wdata(mwdata1), .mem_be(be1)
  );

  dm_store_ctrl #(.ADDR_W(32), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .addr(addr), .wdata(wdata), .DMop(dmop),
    .busy(busy3), .done(done3), .err(err3), .mem_addr(maddr3), .mem_rd(rd3),
    .mem_rdata(rdata3), .mem_wr(wr3), .mem_wdata(mwdata3), .mem_be(be3)
  );

  // Memory read-latency models; data outside the valid cycle is poison.
  logic       pipe1;
  logic [2:0] pipe3;
  always @(posedge clk) begin
    if (rst) begin
      pipe1 <= 1'b0;
      pipe3 <= 3'b000;
    end else begin
      pipe1 <= rd1;
      pipe3 <= {pipe3[1:0], rd3};
    end
  end
  assign rdata1 = pipe1    ? rd_word : 32'hDEAD0001;
  assign rdata3 = pipe3[2] ? rd_word : 32'hDEAD0003;

  logic        o_busy, o_done, o_err, o_rd, o_wr;
  logic [31:0] o_addr, o_wdata;
  logic [3:0]  o_be;
  assign o_busy  = sel ? busy3  : busy1;
  assign o_done  = sel ? done3  : done1;
  assign o_err   = sel ? err3   : err1;
  assign o_rd    = sel ? rd3    : rd1;
  assign o_wr    = sel ? wr3    : wr1;
  assign o_addr  = sel ? maddr3 : maddr1;
  assign o_wdata = sel ? mwdata3 : mwdata1;
  assign o_be    = sel ? be3    : be1;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  int          rd_cyc, wr_cyc, done_cyc, n_rd, n_wr, n_done;
  logic [31:0] rd_addr, wr_addr, wr_data;
  logic [3:0]  wr_be;
  logic        done_err;

  // Issue one request (req high for hold cycles) and log events for 12 cycles.
  // Cycle k is the k-th cycle after the accepting edge.
  task automatic run(input logic s, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] d, input int hold);
    sel = s; dmop = op; addr = a; wdata = d; req = 1'b1;
    rd_cyc = 0; wr_cyc = 0; done_cyc = 0; n_rd = 0; n_wr = 0; n_done = 0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; wr_be = '0; done_err = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k >= hold) begin
        // Scramble inputs once released: the DUT must use its latched copy.
        req = 1'b0; addr = ~a; wdata = ~d; dmop = op ^ 3'b001;
      end
      @(negedge clk);
      if (o_rd) begin
        n_rd++;
        if (rd_cyc == 0) begin rd_cyc = k; rd_addr = o_addr; end
      end
      if (o_wr) begin
        n_wr++;
        if (wr_cyc == 0) begin wr_cyc = k; wr_addr = o_addr; wr_data = o_wdata; wr_be = o_be; end
      end
      if (o_done) begin
        n_done++;
        if (done_cyc == 0) begin done_cyc = k; done_err = o_err; end
      end
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; sel = 1'b0; addr = '0; wdata = '0; dmop = '0; rd_word = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",  o_busy,  0);
    check("rst_done",  o_done,  0);
    check("rst_err",   o_err,   0);
    check("rst_rd",    o_rd,    0);
    check("rst_wr",    o_wr,    0);
    check("rst_addr",  o_addr,  0);
    check("rst_wdata", o_wdata, 0);
    check("rst_be",    o_be,    4'b1111);
    check("rst3_busy", busy3,   0);
    check("rst3_be",   be3,     4'b1111);
    rst = 1'b0;

    // sw aligned
    run(1'b0, 3'b011, 32'h10, 32'hDEADBEEF, 1);
    check("sw_wr_cyc", wr_cyc,   1);
    check("sw_addr",   wr_addr,  32'h10);
    check("sw_data",   wr_data,  32'hDEADBEEF);
    check("sw_be",     wr_be,    4'b1111);
    check("sw_done",   done_cyc, 2);
    check("sw_err",    done_err, 0);
    check("sw_n_rd",   n_rd,     0);

    // sb lane 1
    rd_word = 32'h11223344;
    run(1'b0, 3'b000, 32'h21, 32'h000000AA, 1);
    check("sb_n_rd",   n_rd,     BE ? 0 : 1);
    check("sb_rd_cyc", rd_cyc,   BE ? 0 : 1);
    check("sb_rd_adr", rd_addr,  BE ? 32'h0 : 32'h20);
    check("sb_wr_cyc", wr_cyc,   BE ? 1 : 3);
    check("sb_wr_adr", wr_addr,  32'h20);
    check("sb_data",   wr_data,  BE ? 32'hAAAAAAAA : 32'h1122AA44);
    check("sb_be",     wr_be,    BE ? 4'b0010 : 4'b1111);
    check("sb_done",   done_cyc, BE ? 2 : 4);
    check("sb_err",    done_err, 0);

    // sb lane 3, upper store bits must be ignored
    run(1'b0, 3'b100, 32'h03, 32'h1234565A, 1);
    check("sb3_data",  wr_data,  BE ? 32'h5A5A5A5A : 32'h5A223344);
    check("sb3_be",    wr_be,    BE ? 4'b1000 : 4'b1111);
    check("sb3_wr",    wr_cyc,   BE ? 1 : 3);
    check("sb3_done",  done_cyc, BE ? 2 : 4);

    // sh upper half, RD_LAT=1 then RD_LAT=3
    run(1'b0, 3'b001, 32'h22, 32'h0000BEEF, 1);
    check("sh_data",   wr_data,  BE ? 32'hBEEFBEEF : 32'hBEEF3344);
    check("sh_be",     wr_be,    BE ? 4'b1100 : 4'b1111);
    check("sh_done",   done_cyc, BE ? 2 : 4);
    run(1'b1, 3'b001, 32'h22, 32'h0000BEEF, 1);
    check("sh3_data",  wr_data,  BE ? 32'hBEEFBEEF : 32'hBEEF3344);
    check("sh3_wr",    wr_cyc,   BE ? 1 : 5);
    check("sh3_done",  done_cyc, BE ? 2 : 6);
    check("sh3_n_wr",  n_wr,     1);

    // error cases: done+err next cycle, memory untouched
    run(1'b0, 3'b001, 32'h23, 32'h0000BEEF, 1);
    check("e_sh_done", done_cyc, 1);
    check("e_sh_err",  done_err, 1);
    check("e_sh_acc",  n_rd + n_wr, 0);
    run(1'b0, 3'b011, 32'h26, 32'hCAFEF00D, 1);
    check("e_sw_done", done_cyc, 1);
    check("e_sw_err",  done_err, 1);
    check("e_sw_acc",  n_rd + n_wr, 0);
    run(1'b0, 3'b010, 32'h20, 32'h12345678, 1);
    check("e_op_done", done_cyc, 1);
    check("e_op_err",  done_err, 1);
    check("e_op_acc",  n_rd + n_wr, 0);
    check("e_op_once", n_done, 1);

    // req held through WRITE and DONE: only one store
    run(1'b0, 3'b011, 32'h40, 32'h0BADF00D, 3);
    check("hold_done", n_done, 1);
    check("hold_wr",   n_wr,   1);

    // reset in the second cycle after accept (MERGE in the RMW build)
    sel = 1'b0; dmop = 3'b000; addr = 32'h21; wdata = 32'h000000AA; req = 1'b1;
    n_wr = 0; n_done = 0;
    @(posedge clk); #1; req = 1'b0;
    @(negedge clk); n_wr += int'(o_wr); n_done += int'(o_done);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk); n_wr += int'(o_wr); n_done += int'(o_done);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("mr_busy", o_busy, 0);
    check("mr_rd",   o_rd,   0);
    for (int k = 0; k < 5; k++) begin
      n_wr += int'(o_wr); n_done += int'(o_done);
      @(negedge clk);
    end
    check("mr_n_wr",   n_wr,   BE ? 1 : 0);
    check("mr_n_done", n_done, BE ? 1 : 0);

    // controller usable after the mid-operation reset
    rd_word = 32'hA0B0C0D0;
    run(1'b0, 3'b001, 32'h44, 32'h00001357, 1);
    check("post_data", wr_data,  BE ? 32'h13571357 : 32'hA0B01357);
    check("post_adr",  wr_addr,  32'h44);
    check("post_done", done_cyc, BE ? 2 : 4);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
